// File: rtl/sub32_serial.sv
// sub32_serial
// -----------------------------------------------------------------------------
// Multi-cycle unsigned subtractor with borrow-in/borrow-out:
//   diff = a - b - borrow_in  (mod 2^WIDTH)
// It handles one DIGIT_W-bit slice per clock, least significant slice first.
// Internally the subtraction runs as an add of the inverted subtrahend with
// carry = ~borrow.
//
// Optional feature: define SUB32_OVF_EN to add the overflow_o port, which is
// the signed-overflow flag.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and data until that edge. The
// consumer may drive ready independently of valid.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   a_i, b_i    minuend / subtrahend (WIDTH)
//   borrow_i    borrow-in
//   valid_i     input operands valid
//   ready_o     block can accept operands (state IDLE)
//   diff_o      registered difference (WIDTH)
//   borrow_o    registered borrow-out, 1 when a < b + borrow_i
//   valid_o     result valid (state DONE)
//   ready_i     downstream accepts result
//   overflow_o  signed overflow (only with SUB32_OVF_EN)
module sub32_serial #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             valid_o,
    input  logic             ready_i
`ifdef SUB32_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int STEPS = WIDTH / DIGIT_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q;      // partial difference, built slice by slice
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;
`ifdef SUB32_OVF_EN
    logic               ovf_q;
`endif

    logic [DIGIT_W-1:0] a_sl;
    logic [DIGIT_W-1:0] b_sl;
    logic [DIGIT_W:0]   sum_w;      // MSB is the carry out of this slice
    int                 slice_lo;

    // One slice step: a + ~b + carry. The carry is the inverted borrow.
    always_comb begin
        slice_lo = int'(cnt_q) * DIGIT_W;
        a_sl     = a_q[slice_lo +: DIGIT_W];
        b_sl     = b_q[slice_lo +: DIGIT_W];
        sum_w    = {1'b0, a_sl} + {1'b0, ~b_sl} + {{DIGIT_W{1'b0}}, carry_q};
        acc_d    = acc_q;
        acc_d[slice_lo +: DIGIT_W] = sum_w[DIGIT_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB32_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= ~borrow_i;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= sum_w[DIGIT_W];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Visible outputs change only here, on DONE entry.
                        diff_q   <= acc_d;
                        borrow_q <= ~sum_w[DIGIT_W];
`ifdef SUB32_OVF_EN
                        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                    (acc_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
`ifdef SUB32_OVF_EN
    assign overflow_o = ovf_q;
`endif

endmodule
